// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizing for the writeback arbiter: register tag width,
// default requester/port counts and the per-port write record.
package wb_arbiter_pkg;

  localparam int PHYS_REG_BITS = 7;
  localparam int NUM_WB_REQ    = 4;
  localparam int NUM_WB_PORTS  = 2;

  typedef struct packed {
    logic                     we;
    logic [PHYS_REG_BITS-1:0] wa;
    logic [31:0]              wd;
  } wb_port_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_multi_picker.sv
// Combinational round-robin picker: grants up to NUM_PORTS valid requesters
// scanning from ptr, binds the k-th grant to port k and returns the next pointer.
module rr_multi_picker #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_REQ-1:0]              valid,
  input  logic [IDX_W-1:0]                ptr,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_PORTS-1:0][IDX_W-1:0] port_idx,
  output logic [NUM_PORTS-1:0]            port_used,
  output logic [IDX_W-1:0]                next_ptr
);

  int cnt;
  int pos;

  always_comb begin
    grant     = '0;
    port_idx  = '0;
    port_used = '0;
    next_ptr  = ptr;
    cnt       = 0;
    pos       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      pos = int'(ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      // Only loop variables index the vectors, so the scan unrolls cleanly.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == pos && valid[i] && cnt < NUM_PORTS) begin
          grant[i] = 1'b1;
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (k == cnt) begin
              port_idx[k]  = IDX_W'(i);
              port_used[k] = 1'b1;
            end
          end
          next_ptr = (i == NUM_REQ - 1) ? '0 : IDX_W'(i + 1);
          cnt      = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: fair round-robin sharing of the regfile write ports among
// FU result producers, with registered write ports doubling as wakeup tags.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_WB_REQ,
  parameter int NUM_PORTS = NUM_WB_PORTS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0][PHYS_REG_BITS-1:0]   req_prd,
  input  logic [NUM_REQ-1:0][31:0]                req_data,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [NUM_PORTS-1:0]                    wb_we,
  output logic [NUM_PORTS-1:0][PHYS_REG_BITS-1:0] wb_wa,
  output logic [NUM_PORTS-1:0][31:0]              wb_wd,
  output logic [NUM_PORTS-1:0]                    wakeup_valid,
  output logic [NUM_PORTS-1:0][PHYS_REG_BITS-1:0] wakeup_prd
);

  localparam int IDX_W = idx_bits(NUM_REQ);

  logic [IDX_W-1:0]                     rr_ptr_reg;
  logic [IDX_W-1:0]                     rr_ptr_next;
  logic [NUM_REQ-1:0]                   grant;
  logic [NUM_PORTS-1:0][IDX_W-1:0]      port_idx;
  logic [NUM_PORTS-1:0]                 port_used;
  logic [NUM_PORTS-1:0]                 port_we_next;
  logic [NUM_PORTS-1:0][PHYS_REG_BITS-1:0] port_wa_next;
  logic                                 dup_prd;

  rr_multi_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .valid     (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .port_idx  (port_idx),
    .port_used (port_used),
    .next_ptr  (rr_ptr_next)
  );

  // No transfer may be accepted while reset holds the output registers clear.
  assign req_ready = rst ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_reg <= '0;
    else      rr_ptr_reg <= rr_ptr_next;
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      wb_port_t port_next;
      wb_port_t port_reg;

      // prd==0 still uses the slot but never writes or wakes anything.
      always_comb begin
        port_next = '0;
        if (port_used[gi]) begin
          port_next.we = |req_prd[port_idx[gi]];
          port_next.wa = req_prd[port_idx[gi]];
          port_next.wd = req_data[port_idx[gi]];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) port_reg <= '0;
        else      port_reg <= port_next;
      end

      assign port_we_next[gi] = port_next.we;
      assign port_wa_next[gi] = port_next.wa;
      assign wb_we[gi]        = port_reg.we;
      assign wb_wa[gi]        = port_reg.wa;
      assign wb_wd[gi]        = port_reg.wd;
      assign wakeup_valid[gi] = port_reg.we;
      assign wakeup_prd[gi]   = port_reg.wa;
    end
  endgenerate

  always_comb begin
    dup_prd = 1'b0;
    for (int a = 0; a < NUM_PORTS; a++) begin
      for (int b = a + 1; b < NUM_PORTS; b++) begin
        if (port_we_next[a] && port_we_next[b] && port_wa_next[a] == port_wa_next[b])
          dup_prd = 1'b1;
      end
    end
  end

  // Renaming guarantees unique destinations among same-cycle grants.
  a_no_dup_prd: assert property (@(posedge clk) disable iff (!rst) !dup_prd);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, fairness, wrap-around, prd==0,
// idle cycles and asynchronous reset mid-stream, with a behavioural regfile.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NP = 2;
  localparam int PB = PHYS_REG_BITS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][PB-1:0]  req_prd;
  logic [NR-1:0][31:0]    req_data;
  logic [NR-1:0]          req_ready;
  logic [NP-1:0]          wb_we;
  logic [NP-1:0][PB-1:0]  wb_wa;
  logic [NP-1:0][31:0]    wb_wd;
  logic [NP-1:0]          wakeup_valid;
  logic [NP-1:0][PB-1:0]  wakeup_prd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_prd      (req_prd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wb_we        (wb_we),
    .wb_wa        (wb_wa),
    .wb_wd        (wb_wd),
    .wakeup_valid (wakeup_valid),
    .wakeup_prd   (wakeup_prd)
  );

  // Behavioural regfile fed by the write ports.
  logic [31:0] rf_model [128];
  bit          rf_clear = 1'b1;

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 128; i++) rf_model[i] <= '0;
    end else begin
      for (int k = 0; k < NP; k++)
        if (wb_we[k]) rf_model[wb_wa[k]] <= wb_wd[k];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction: present valids on the falling edge, check grants, then
  // step past the rising edge so registered outputs can be checked.
  task automatic drive(input string tag, input logic [NR-1:0] v, input logic [NR-1:0] exp_ready);
    @(negedge clk);
    req_valid = v;
    #1;
    check_eq({tag, " ready"}, 64'(req_ready), 64'(exp_ready));
    $display("[TB] cyc %0d %s valid=%b ready=%b", cyc, tag, v, req_ready);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [NR-1:0] fair_ready [4] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
  logic [PB-1:0] fair_wa0   [4] = '{7'd1, 7'd3, 7'd5, 7'd7};
  logic [PB-1:0] fair_wa1   [4] = '{7'd2, 7'd4, 7'd6, 7'd8};
  logic [31:0]   fair_wd0   [4] = '{32'h000, 32'h200, 32'h001, 32'h201};
  logic [31:0]   fair_wd1   [4] = '{32'h100, 32'h300, 32'h101, 32'h301};
  logic [1:0]    fair_ptr   [4] = '{2'd2, 2'd0, 2'd2, 2'd0};

  initial begin
    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      req_prd[i]  = PB'(i + 1);
      req_data[i] = 32'(i) << 8;
    end
    repeat (2) @(posedge clk);
    rf_clear  = 1'b0;
    req_valid = 4'b1111;

    // Held in reset with everything valid.
    @(negedge clk);
    #1;
    check_eq("rst ready", 64'(req_ready), 64'h0);
    check_eq("rst wb_we", 64'(wb_we), 64'h0);
    check_eq("rst wb_wa", 64'(wb_wa), 64'h0);
    check_eq("rst wb_wd", 64'(wb_wd), 64'h0);
    check_eq("rst wakeup_valid", 64'(wakeup_valid), 64'h0);
    check_eq("rst wakeup_prd", 64'(wakeup_prd), 64'h0);
    @(posedge clk);
    #1;
    check_eq("rst hold wb_we", 64'(wb_we), 64'h0);
    check_eq("rst rr_ptr", 64'(dut.rr_ptr_reg), 64'h0);
    #1;
    rst = 1'b1;

    // Fairness: all four valid, granted requesters re-present new results.
    for (int c = 0; c < 4; c++) begin
      drive($sformatf("fair%0d", c), 4'b1111, fair_ready[c]);
      check_eq($sformatf("fair%0d wb_we", c), 64'(wb_we), 64'h3);
      check_eq($sformatf("fair%0d wa0", c), 64'(wb_wa[0]), 64'(fair_wa0[c]));
      check_eq($sformatf("fair%0d wa1", c), 64'(wb_wa[1]), 64'(fair_wa1[c]));
      check_eq($sformatf("fair%0d wd0", c), 64'(wb_wd[0]), 64'(fair_wd0[c]));
      check_eq($sformatf("fair%0d wd1", c), 64'(wb_wd[1]), 64'(fair_wd1[c]));
      check_eq($sformatf("fair%0d rr_ptr", c), 64'(dut.rr_ptr_reg), 64'(fair_ptr[c]));
      for (int i = 0; i < NR; i++) begin
        if (fair_ready[c][i]) begin
          req_prd[i]  = req_prd[i] + PB'(4);
          req_data[i] = req_data[i] + 32'd1;
        end
      end
    end

    // Idle: no hold of the previous writes, pointer unchanged.
    drive("idle", 4'b0000, 4'b0000);
    check_eq("idle wb_we", 64'(wb_we), 64'h0);
    check_eq("idle rr_ptr", 64'(dut.rr_ptr_reg), 64'h0);

    // Single request from req2.
    req_prd[2]  = 7'd45;
    req_data[2] = 32'hDEADBEEF;
    drive("single", 4'b0100, 4'b0100);
    check_eq("single wb_we", 64'(wb_we), 64'h1);
    check_eq("single wa0", 64'(wb_wa[0]), 64'd45);
    check_eq("single wd0", 64'(wb_wd[0]), 64'hDEADBEEF);
    check_eq("single wakeup_prd0", 64'(wakeup_prd[0]), 64'd45);
    check_eq("single wakeup_valid", 64'(wakeup_valid), 64'h1);
    check_eq("single rr_ptr", 64'(dut.rr_ptr_reg), 64'd3);

    // Wrap-around from rr_ptr=3.
    req_prd[3]  = 7'd20;
    req_data[3] = 32'd33;
    req_prd[0]  = 7'd21;
    req_data[0] = 32'd44;
    drive("wrap", 4'b1001, 4'b1001);
    check_eq("wrap wb_we", 64'(wb_we), 64'h3);
    check_eq("wrap wa0", 64'(wb_wa[0]), 64'd20);
    check_eq("wrap wa1", 64'(wb_wa[1]), 64'd21);
    check_eq("wrap wd0", 64'(wb_wd[0]), 64'd33);
    check_eq("wrap wd1", 64'(wb_wd[1]), 64'd44);
    check_eq("wrap rr_ptr", 64'(dut.rr_ptr_reg), 64'd1);
    check_eq("rf read 45", 64'(rf_model[45]), 64'hDEADBEEF);

    // prd==0 consumes a slot without a write.
    req_prd[0]  = 7'd0;
    req_data[0] = 32'd55;
    drive("prd0", 4'b0001, 4'b0001);
    check_eq("prd0 wb_we", 64'(wb_we), 64'h0);
    check_eq("prd0 wakeup_valid", 64'(wakeup_valid), 64'h0);
    check_eq("prd0 rr_ptr", 64'(dut.rr_ptr_reg), 64'd1);
    check_eq("rf read 20", 64'(rf_model[20]), 64'd33);

    // Three valid from rr_ptr=1: req1 and req3 win, req0 waits.
    req_prd[0]  = 7'd40;
    req_data[0] = 32'd88;
    req_prd[1]  = 7'd30;
    req_data[1] = 32'd66;
    req_prd[3]  = 7'd31;
    req_data[3] = 32'd77;
    drive("three", 4'b1011, 4'b1010);
    check_eq("three wb_we", 64'(wb_we), 64'h3);
    check_eq("three wa0", 64'(wb_wa[0]), 64'd30);
    check_eq("three wa1", 64'(wb_wa[1]), 64'd31);
    check_eq("three rr_ptr", 64'(dut.rr_ptr_reg), 64'd0);

    // Reset right after a grant: outputs clear without a clock edge.
    req_prd[1]  = 7'd100;
    req_data[1] = 32'h1111;
    req_prd[2]  = 7'd101;
    req_data[2] = 32'h2222;
    req_prd[3]  = 7'd102;
    req_data[3] = 32'h3333;
    drive("midrst", 4'b1111, 4'b0011);
    check_eq("midrst wb_we pre", 64'(wb_we), 64'h3);
    check_eq("midrst wa0 pre", 64'(wb_wa[0]), 64'd40);
    #1;
    rst = 1'b0;
    #1;
    check_eq("midrst wb_we", 64'(wb_we), 64'h0);
    check_eq("midrst wakeup_valid", 64'(wakeup_valid), 64'h0);
    check_eq("midrst ready", 64'(req_ready), 64'h0);
    check_eq("midrst rr_ptr", 64'(dut.rr_ptr_reg), 64'h0);
    @(posedge clk);
    #1;
    check_eq("midrst rf 40", 64'(rf_model[40]), 64'h0);
    check_eq("midrst rf 100", 64'(rf_model[100]), 64'h0);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
